// File: rtl/jpeg_frame_ctrl_pkg.sv
// Shared bus/sim macros, frame controller state encoding and MCU geometry.
// The macros are guarded so any file of the slice may also define them standalone.
`ifndef IN_BUS_WIDTH
`define IN_BUS_WIDTH 32
`endif
`ifndef PERIOD
`define PERIOD 10
`endif

package jpeg_frame_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int MCU_DIM     = 16;
    localparam int BLK_DIM     = 8;
    localparam int BLK_PER_MCU = 4;

endpackage

// File: rtl/mcu_block_tracker.sv
// Walks output blocks in MCU order (2x2 blocks per MCU, MCUs raster order) and
// presents the current block's pixel origin, sequence number and last-block flag.
module mcu_block_tracker
    import jpeg_frame_ctrl_pkg::*;
#(
    parameter int DIM_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clr,
    input  logic               i_adv,
    input  logic [DIM_W-1:0]   i_mcus_x,
    input  logic [DIM_W-1:0]   i_mcus_y,
    output logic [DIM_W-1:0]   o_x,
    output logic [DIM_W-1:0]   o_y,
    output logic [2*DIM_W-1:0] o_idx,
    output logic               o_last
);

    logic [1:0]         r_sub;
    logic [DIM_W-1:0]   r_col;
    logic [DIM_W-1:0]   r_row;
    logic [2*DIM_W-1:0] r_idx;

    logic w_sub_wrap;
    logic w_col_wrap;

    assign w_sub_wrap = (r_sub == 2'(BLK_PER_MCU - 1));
    assign w_col_wrap = (r_col == i_mcus_x - DIM_W'(1));

    always_ff @(posedge clk) begin
        if (!rst || i_clr) begin
            r_sub <= '0;
            r_col <= '0;
            r_row <= '0;
            r_idx <= '0;
        end else if (i_adv) begin
            r_idx <= r_idx + (2*DIM_W)'(1);
            if (w_sub_wrap) begin
                r_sub <= '0;
                if (w_col_wrap) begin
                    r_col <= '0;
                    r_row <= r_row + DIM_W'(1);
                end else begin
                    r_col <= r_col + DIM_W'(1);
                end
            end else begin
                r_sub <= r_sub + 2'd1;
            end
        end
    end

    // sub[0] selects the right-hand block, sub[1] the lower block of the MCU
    assign o_x    = (r_col << $clog2(MCU_DIM)) | (r_sub[0] ? DIM_W'(BLK_DIM) : '0);
    assign o_y    = (r_row << $clog2(MCU_DIM)) | (r_sub[1] ? DIM_W'(BLK_DIM) : '0);
    assign o_idx  = r_idx;
    assign o_last = w_sub_wrap && w_col_wrap && (r_row == i_mcus_y - DIM_W'(1));

endmodule

// File: rtl/jpeg_frame_ctrl.sv
// Frame controller: streams bitstream words to the decoder (zero-latency passthrough),
// flushes with the last word until all blocks arrive, and tags each block one cycle later.
module jpeg_frame_ctrl
    import jpeg_frame_ctrl_pkg::*;
#(
    parameter int DIM_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [DIM_W-1:0]         img_width,
    input  logic [DIM_W-1:0]         img_height,
    input  logic [`IN_BUS_WIDTH-1:0] src_data,
    input  logic                     src_valid,
    input  logic                     src_last,
    output logic                     src_ready,
    input  logic                     dec_request,
    output logic [`IN_BUS_WIDTH-1:0] dec_data_in,
    output logic                     dec_valid_in,
    input  logic                     valid_out_Color,
    output logic                     blk_valid,
    output logic [DIM_W-1:0]         blk_x,
    output logic [DIM_W-1:0]         blk_y,
    output logic [2*DIM_W-1:0]       blk_idx,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    state_t r_state;
    state_t w_state_nxt;

    logic [DIM_W-1:0]         r_mcus_x;
    logic [DIM_W-1:0]         r_mcus_y;
    logic [`IN_BUS_WIDTH-1:0] r_last_word;
    logic                     r_blk_valid;
    logic [DIM_W-1:0]         r_blk_x;
    logic [DIM_W-1:0]         r_blk_y;
    logic [2*DIM_W-1:0]       r_blk_idx;
    logic                     r_err;

    logic                     w_can_start;
    logic                     w_dims_ok;
    logic                     w_start_ok;
    logic                     w_start_bad;
    logic                     w_active;
    logic                     w_count;
    logic                     w_stray;
    logic [DIM_W:0]           w_wsum;
    logic [DIM_W:0]           w_hsum;
    logic [DIM_W-1:0]         w_trk_x;
    logic [DIM_W-1:0]         w_trk_y;
    logic [2*DIM_W-1:0]       w_trk_idx;
    logic                     w_trk_last;

    assign w_can_start = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_dims_ok   = (|img_width) && (|img_height);
    assign w_start_ok  = start && w_can_start && w_dims_ok;
    assign w_start_bad = start && w_can_start && !w_dims_ok;
    assign w_active    = (r_state == ST_FEED) || (r_state == ST_DRAIN);
    assign w_count     = valid_out_Color && w_active;
    assign w_stray     = valid_out_Color && !w_active;

    // One extra bit so rounding up a near-max dimension cannot wrap
    assign w_wsum = {1'b0, img_width}  + (DIM_W+1)'(MCU_DIM - 1);
    assign w_hsum = {1'b0, img_height} + (DIM_W+1)'(MCU_DIM - 1);

    mcu_block_tracker #(
        .DIM_W (DIM_W)
    ) u_tracker (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_start_ok),
        .i_adv    (w_count),
        .i_mcus_x (r_mcus_x),
        .i_mcus_y (r_mcus_y),
        .o_x      (w_trk_x),
        .o_y      (w_trk_y),
        .o_idx    (w_trk_idx),
        .o_last   (w_trk_last)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        src_ready    = 1'b0;
        dec_valid_in = 1'b0;
        dec_data_in  = src_data;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) w_state_nxt = ST_FEED;
            end
            ST_FEED: begin
                busy         = 1'b1;
                src_ready    = dec_request;
                dec_valid_in = src_valid && dec_request;
                // Final block wins: leftover source words are simply never accepted
                if (w_count && w_trk_last) begin
                    w_state_nxt = ST_DONE;
                end else if (src_valid && dec_request && src_last) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy         = 1'b1;
                dec_valid_in = dec_request;
                dec_data_in  = r_last_word;
                if (w_count && w_trk_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (w_start_ok) w_state_nxt = ST_FEED;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (!rst) begin
            src_ready    = 1'b0;
            dec_valid_in = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mcus_x    <= '0;
            r_mcus_y    <= '0;
            r_last_word <= '0;
            r_blk_valid <= 1'b0;
            r_blk_x     <= '0;
            r_blk_y     <= '0;
            r_blk_idx   <= '0;
            r_err       <= 1'b0;
        end else begin
            if (src_valid && src_ready) r_last_word <= src_data;
            if (w_start_ok) begin
                r_mcus_x <= DIM_W'(w_wsum >> $clog2(MCU_DIM));
                r_mcus_y <= DIM_W'(w_hsum >> $clog2(MCU_DIM));
            end
            r_blk_valid <= w_count;
            if (w_count) begin
                r_blk_x   <= w_trk_x;
                r_blk_y   <= w_trk_y;
                r_blk_idx <= w_trk_idx;
            end
            if (w_start_ok) begin
                r_err <= w_stray;
            end else if (w_start_bad || w_stray) begin
                r_err <= 1'b1;
            end
        end
    end

    assign blk_valid = r_blk_valid && rst;
    assign blk_x     = r_blk_x;
    assign blk_y     = r_blk_y;
    assign blk_idx   = r_blk_idx;
    assign err       = r_err;

endmodule
